m__fetch_stage: RTL

Instruction fetch stage sitting directly downstream of the program counter in the 5-stage MIPS pipeline. Takes the current PC, runs a req/ack fetch against instruction memory, and loads the IF/ID pipeline register (instruction, PC, PC+4, valid). It also generates the PC's write enable, so the PC advances only when a fetched instruction is accepted or a branch flush redirects it. It absorbs memory wait states, decode stalls and branch flushes.

---
 rtl/m__fetch_stage_if.sv | 12 +
 rtl/m__fetch_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/m__fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface m__fetch_stage_if;
   logic        imemReq__o;
   logic [31:0] imemAddr__o;
   logic        imemAck__i;
   logic [31:0] imemData__i;

   modport master (output imemReq__o, output imemAddr__o,
                   input  imemAck__i, input  imemData__i);
   modport slave  (input  imemReq__o, input  imemAddr__o,
                   output imemAck__i, output imemData__i);
endinterface

// File: rtl/m__fetch_stage.sv
// Instruction fetch stage: req/ack fetch from imem into the IF/ID register,
// PC write-enable generation, and handling of memory waits, stalls and flushes.
//
// state | meaning
// ISSUE | latch PC into addr_q, no request outstanding
// WAIT  | request outstanding for addr_q, result still wanted
// HOLD  | fetched word parked in buf_q while decode is stalled
// DROP  | request outstanding but squashed; wait out the ack and discard it
module m__fetch_stage (
   input  logic                   clock__i,
   input  logic                   reset__i,
   input  logic [31:0]            pc__i,
   output logic                   pcWrite__o,
   m__fetch_stage_if.master       imem,
   input  logic                   stall__i,
   input  logic                   flush__i,
   output logic [31:0]            ifidInstr__o,
   output logic [31:0]            ifidPc__o,
   output logic [31:0]            ifidPcPlus4__o,
   output logic                   ifidValid__o
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INCR   = 32'd4;

   typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        req;
   logic        addr_we;
   logic        buf_we;
   logic        load_mem;
   logic        load_buf;

   // State register; async reset returns to ISSUE so the request drops at once.
   always_ff @(posedge clock__i or posedge reset__i) begin
      if (reset__i) state_q <= ISSUE;
      else          state_q <= state_d;
   end

   // Next-state selection; flush always outranks stall.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ISSUE: state_d = flush__i ? ISSUE : WAIT;
         WAIT: begin
            if (imem.imemAck__i) begin
               if (flush__i)      state_d = ISSUE;
               else if (stall__i) state_d = HOLD;
               else               state_d = ISSUE;
            end else if (flush__i) begin
               state_d = DROP;
            end
         end
         HOLD: if (flush__i || !stall__i) state_d = ISSUE;
         DROP: if (imem.imemAck__i) state_d = ISSUE;
         default: state_d = ISSUE;
      endcase
   end

   // Per-state control strobes for the datapath and the memory request.
   always_comb begin
      req      = 1'b0;
      addr_we  = 1'b0;
      buf_we   = 1'b0;
      load_mem = 1'b0;
      load_buf = 1'b0;
      case (state_q)
         ISSUE: addr_we = 1'b1;
         WAIT: begin
            req = 1'b1;
            if (imem.imemAck__i && !flush__i) begin
               if (stall__i) buf_we   = 1'b1;
               else          load_mem = 1'b1;
            end
         end
         HOLD: if (!flush__i && !stall__i) load_buf = 1'b1;
         DROP: req = 1'b1;
         default: ;
      endcase
   end

   assign imem.imemReq__o  = req;
   assign imem.imemAddr__o = addr_q;
   // Gated by reset so the PC is never written while the stage is held in reset.
   assign pcWrite__o       = !reset__i && (load_mem || load_buf || flush__i);

   // Datapath next values: fetch address, stall buffer and IF/ID register.
   always_comb begin
      addr_d  = addr_we ? pc__i : addr_q;
      buf_d   = buf_we ? imem.imemData__i : buf_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush__i) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (stall__i) begin
         valid_d = valid_q;
      end else if (load_mem || load_buf) begin
         instr_d = load_mem ? imem.imemData__i : buf_q;
         pc_d    = addr_q;
         pc4_d   = addr_q + PC_INCR;
         valid_d = 1'b1;
      end else begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clock__i or posedge reset__i) begin
      if (reset__i) begin
         addr_q  <= '0;
         buf_q   <= '0;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         buf_q   <= buf_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign ifidInstr__o   = instr_q;
   assign ifidPc__o      = pc_q;
   assign ifidPcPlus4__o = pc4_q;
   assign ifidValid__o   = valid_q;

endmodule
